myproject_dense_acc_requant: RTL and testbench

//  Downstream stage of a dense-layer product unit (8s x 8ns -> 16-bit signed products).
//  - Consumes one signed product per beat and sums N_IN products plus a bias into one neuron result.
//  - Rounds, optionally applies ReLU, saturates to OUT_W bits, and presents the result on a valid/ready output.
//  - One instance per neuron lane in the hls4ml-style datapath.

---
 rtl/myproject_dense_pkg.sv | 43 ++++
 rtl/myproject_acc_requant.sv | 18 +
 rtl/myproject_dense_acc_requant.sv | 108 ++++++++++
 tb/tb_myproject_dense_acc_requant.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_dense_pkg.sv
// Shared widths, accumulator type and the round/ReLU/saturate helper
// used by the dense-layer accumulate/requantise stages.
package myproject_dense_pkg;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;

  typedef logic signed [ACC_W-1:0] acc_t;

  // Returns {overflow, data}. Work is done at ACC_W+1 bits so the
  // rounding add cannot wrap.
  function automatic logic [OUT_W:0] sat_round(
    input acc_t x,
    input int   shift,
    input int   out_w,
    input bit   relu
  );
    logic signed [ACC_W:0] xe;
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] one;
    logic signed [ACC_W:0] mx;
    xe  = {x[ACC_W-1], x};
    one = {{ACC_W{1'b0}}, 1'b1};
    if (shift > 0) begin
      r = (xe + (one <<< (shift - 1))) >>> shift;
    end else begin
      r = xe;
    end
    if (relu && r[ACC_W]) begin
      r = '0;
    end
    mx = (one <<< (out_w - 1)) - one;
    if (r > mx) begin
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
    if (r < ~mx) begin
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end
    return {1'b0, r[OUT_W-1:0]};
  endfunction

endpackage

// File: rtl/myproject_acc_requant.sv
// Combinational post-processing: round, optional ReLU, saturate.
// Ports: x (accumulated sum) -> data (OUT_W signed), ovf (saturated).
module myproject_acc_requant
  import myproject_dense_pkg::*;
#(
  parameter int SHIFT = 6,
  parameter int RELU  = 0
) (
  input  acc_t                    x,
  output logic signed [OUT_W-1:0] data,
  output logic                    ovf
);

  always_comb begin
    {ovf, data} = sat_round(x, SHIFT, OUT_W, RELU != 0);
  end

endmodule

// File: rtl/myproject_dense_acc_requant.sv
// Sums N_IN signed products plus bias, requantises, and holds the
// result on a valid/ready output. Ports: s_* in, m_* out, busy.
module myproject_dense_acc_requant
  import myproject_dense_pkg::*;
#(
  parameter int BIAS_W = 16,
  parameter int N_IN   = 16,
  parameter int SHIFT  = 6,
  parameter int RELU   = 0
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [PROD_W-1:0] s_prod,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     m_overflow,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy
);

  localparam int MAX_IN = (PROD_W > BIAS_W) ? PROD_W : BIAS_W;
  localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

  if (ACC_W < MAX_IN + $clog2(N_IN + 1) + 1) begin : g_acc_chk
    $fatal(1, "ACC_W too narrow for N_IN and input widths");
  end
  if (SHIFT < 0 || SHIFT > ACC_W - 2) begin : g_shift_chk
    $fatal(1, "SHIFT out of range");
  end

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  acc_t                    acc_q, acc_d;
  logic                    m_valid_q, m_valid_d;
  logic signed [OUT_W-1:0] m_data_q, m_data_d;
  logic                    m_ovf_q, m_ovf_d;

  logic                    first;
  logic                    last;
  logic                    fire;
  acc_t                    sum;
  logic signed [OUT_W-1:0] post_data;
  logic                    post_ovf;

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == CNT_W'(N_IN - 1));

  assign s_ready = ~last | ~m_valid_q | m_ready;
  assign fire    = s_valid & s_ready;

  // Beat 0 starts from the bias, so N_IN==1 needs no special case.
  assign sum = (first ? ACC_W'(bias) : acc_q) + ACC_W'(s_prod);

  myproject_acc_requant #(
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_post (
    .x    (sum),
    .data (post_data),
    .ovf  (post_ovf)
  );

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ovf_d   = m_ovf_q;
    if (m_valid_q & m_ready) begin
      m_valid_d = 1'b0;
    end
    if (fire) begin
      acc_d = sum;
      if (last) begin
        cnt_d     = '0;
        m_valid_d = 1'b1;
        m_data_d  = post_data;
        m_ovf_d   = post_ovf;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_overflow = m_ovf_q;
  assign busy       = (cnt_q != '0) | m_valid_q;

endmodule

// File: tb/tb_myproject_dense_acc_requant.sv
// Scoreboard bench: RELU=0 and RELU=1 instances share one stream.
// N_IN=4, SHIFT=6, OUT_W=8.
module tb_myproject_dense_acc_requant;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] s_prod;
  logic               s_valid;
  logic signed [15:0] bias;
  logic               m_ready;

  logic               s_ready0, s_ready1;
  logic signed [7:0]  m_data0, m_data1;
  logic               m_ovf0, m_ovf1;
  logic               m_valid0, m_valid1;
  logic               busy0, busy1;

  int n_checks = 0;
  int n_err    = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  logic              hold_v = 1'b0;
  logic signed [7:0] hold_d;
  logic              hold_o;

  always #5 clk = ~clk;

  myproject_dense_acc_requant #(
    .BIAS_W(16), .N_IN(4), .SHIFT(6), .RELU(0)
  ) dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_prod(s_prod), .s_valid(s_valid), .s_ready(s_ready0),
    .bias(bias),
    .m_data(m_data0), .m_overflow(m_ovf0),
    .m_valid(m_valid0), .m_ready(m_ready),
    .busy(busy0)
  );

  myproject_dense_acc_requant #(
    .BIAS_W(16), .N_IN(4), .SHIFT(6), .RELU(1)
  ) dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_prod(s_prod), .s_valid(s_valid), .s_ready(s_ready1),
    .bias(bias),
    .m_data(m_data1), .m_overflow(m_ovf1),
    .m_valid(m_valid1), .m_ready(m_ready),
    .busy(busy1)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input int sum, input bit relu);
    int r;
    r = (sum + 32) >>> 6;
    if (relu && r < 0) r = 0;
    if (r > 127) return {1'b1, 8'h7f};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, r[7:0]};
  endfunction

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else if (m_valid0 && m_ready) begin
      hold_v = 1'b0;
      if (q0.size() == 0 || q1.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("data", m_data0, $signed(e[7:0]));
        chk("ovf", m_ovf0, e[8]);
        e = q1.pop_front();
        chk("relu_valid", m_valid1, 1);
        chk("relu_data", m_data1, $signed(e[7:0]));
        chk("relu_ovf", m_ovf1, e[8]);
      end
    end else if (m_valid0) begin
      if (hold_v) begin
        chk("hold_data", m_data0, hold_d);
        chk("hold_ovf", m_ovf0, hold_o);
      end
      hold_v = 1'b1;
      hold_d = m_data0;
      hold_o = m_ovf0;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic beat(input logic signed [15:0] p,
                      input logic signed [15:0] b);
    int n;
    bit ok;
    s_valid = 1'b1;
    s_prod  = p;
    bias    = b;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = s_ready0;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  task automatic neuron(input int b, input int p0, input int p1,
                        input int p2, input int p3, input bit lat);
    int p[4];
    int sum;
    p   = '{p0, p1, p2, p3};
    sum = b;
    for (int i = 0; i < 4; i++) sum += p[i];
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        q0.push_back(model(sum, 1'b0));
        q1.push_back(model(sum, 1'b1));
        if (lat) chk("pre_valid", m_valid0, 0);
      end
      if (!lat && $urandom_range(1, 0) == 1) begin
        @(posedge clk);
        #1;
      end
      beat(16'(p[i]), (i == 0) ? 16'(b) : 16'($urandom));
    end
    if (lat) chk("latency", m_valid0, 1);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_prod  = '0;
    bias    = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid0, 0);
    chk("rst_data", m_data0, 0);
    chk("rst_ovf", m_ovf0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", s_ready0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    neuron(0, 64, 64, 64, 64, 1'b1);
    neuron(0, 32, 0, 0, 0, 1'b0);
    neuron(0, -32, 0, 0, 0, 1'b0);
    neuron(0, -33, 0, 0, 0, 1'b0);
    neuron(0, 16384, 16384, 16384, 16384, 1'b0);
    neuron(0, -16384, -16384, -16384, -16384, 1'b0);
    neuron(0, 8128, 0, 0, 0, 1'b0);
    neuron(0, 8160, 0, 0, 0, 1'b0);
    neuron(0, -8192, 0, 0, 0, 1'b0);
    neuron(0, -8225, 0, 0, 0, 1'b0);
    neuron(-640, 0, 0, 0, 0, 1'b0);
    neuron(-640, 0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      neuron($urandom_range(4000, 0) - 2000,
             $urandom_range(4000, 0) - 2000,
             $urandom_range(4000, 0) - 2000,
             $urandom_range(4000, 0) - 2000,
             $urandom_range(4000, 0) - 2000, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;

    m_ready = 1'b0;
    neuron(100, 200, 300, 400, 500, 1'b1);
    beat(16'sd640, 16'sd0);
    beat(16'sd640, 16'sd0);
    beat(16'sd640, 16'sd0);
    chk("bp_busy", busy0, 1);
    q0.push_back(model(2560, 1'b0));
    q1.push_back(model(2560, 1'b1));
    s_valid = 1'b1;
    s_prod  = 16'sd640;
    bias    = 16'sd7;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", s_ready0, 0);
      chk("bp_valid", m_valid0, 1);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", s_ready0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("bp_b_valid", m_valid0, 1);
    chk("bp_b_data", m_data0, 40);
    @(posedge clk);
    #1;
    chk("bp_drain", m_valid0, 0);

    beat(16'sd1000, 16'sd1000);
    beat(16'sd1000, 16'sd0);
    chk("mid_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid0, 0);
    chk("mid_rst_data", m_data0, 0);
    chk("mid_rst_ovf", m_ovf0, 0);
    chk("mid_rst_busy", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    neuron(0, 64, 64, 64, 64, 1'b1);

    n = 0;
    while ((q0.size() != 0 || m_valid0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", q0.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
